// File: rtl/bus_interconnect_n.sv
// bus_interconnect_n: single-master, N-slave interconnect for the rysyCore data port.
// Decodes the master address against a base/mask map, forwards the transaction to
// the selected slave and returns its data, or an error for unmapped/timed-out accesses.
module bus_interconnect_n #(
  parameter int                          WIDTH     = 32,
  parameter int                          N_SLAVES  = 2,
  parameter logic [N_SLAVES*WIDTH-1:0]   ADDR_BASE = {32'h0001_0000, 32'h0},
  parameter logic [N_SLAVES*WIDTH-1:0]   ADDR_MASK = {2{32'hFFFF_0000}},
  parameter int                          TIMEOUT   = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req,
  input  logic                      we,
  input  logic [WIDTH-1:0]          addr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [WIDTH/8-1:0]        be,
  output logic [WIDTH-1:0]          rdata,
  output logic                      ack,
  output logic                      err,
  output logic [7:0]                err_count,
  output logic [N_SLAVES-1:0]       s_req,
  output logic                      s_we,
  output logic [WIDTH-1:0]          s_addr,
  output logic [WIDTH-1:0]          s_wdata,
  output logic [WIDTH/8-1:0]        s_be,
  input  logic [N_SLAVES*WIDTH-1:0] s_rdata,
  input  logic [N_SLAVES-1:0]       s_ready
);

  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] sel_q;
  logic [IDX_W-1:0] hit_idx;
  logic             hit;
  logic [7:0]       tmo_cnt;
  logic             tmo_hit;
  logic             sel_ready;
  logic [WIDTH-1:0] sel_rdata;

  // Error counter sticks at its maximum instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Address decode; scanning high to low lets the lowest matching slave win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((addr & ADDR_MASK[i*WIDTH +: WIDTH]) == ADDR_BASE[i*WIDTH +: WIDTH]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Pick ready and read data of the latched slave; other slaves are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_q == IDX_W'(i)) begin
        sel_ready = s_ready[i];
        sel_rdata = s_rdata[i*WIDTH +: WIDTH];
      end
    end
  end

  assign tmo_hit = (tmo_cnt == 8'(TIMEOUT));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: ready beats timeout when both occur in the same WAIT cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = hit ? WAIT : RESP;
      WAIT:    if (sel_ready || tmo_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction registers: latch request, drive slave, capture response and errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata     <= '0;
      ack       <= 1'b0;
      err       <= 1'b0;
      err_count <= 8'd0;
      s_req     <= '0;
      s_we      <= 1'b0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_be      <= '0;
      sel_q     <= '0;
      tmo_cnt   <= 8'd0;
    end else begin
      ack <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            if (hit) begin
              s_we    <= we;
              s_addr  <= addr;
              s_wdata <= wdata;
              s_be    <= be;
              sel_q   <= hit_idx;
              s_req   <= N_SLAVES'(1) << hit_idx;
              tmo_cnt <= 8'd0;
            end else begin
              rdata     <= '0;
              err       <= 1'b1;
              err_count <= sat_inc(err_count);
              ack       <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (sel_ready) begin
            rdata <= s_we ? '0 : sel_rdata;
            err   <= 1'b0;
            ack   <= 1'b1;
            s_req <= '0;
          end else if (tmo_hit) begin
            rdata     <= '0;
            err       <= 1'b1;
            err_count <= sat_inc(err_count);
            ack       <= 1'b1;
            s_req     <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        RESP: begin
          s_req   <= '0;
          tmo_cnt <= 8'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_interconnect_n.sv
// Testbench for bus_interconnect_n: directed vector table, hand sequences for
// back-to-back, reset and overlapping-map cases, and randomized traffic against
// a behavioural address-map/latency model.
module tb_bus_interconnect_n;
  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  logic [31:0] rdata;
  logic        ack, err;
  logic [7:0]  err_count;
  logic [1:0]  s_req;
  logic        s_we;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;
  logic [63:0] s_rdata = '0;
  logic [1:0]  s_ready = '0;

  // second instance with a fully overlapping map
  logic        ov_req = 1'b0;
  logic [1:0]  ov_s_ready = '0;
  logic [31:0] ov_rdata;
  logic        ov_ack, ov_err;
  logic [7:0]  ov_err_count;
  logic [1:0]  ov_s_req;
  logic        ov_s_we;
  logic [31:0] ov_s_addr, ov_s_wdata;
  logic [3:0]  ov_s_be;

  int checks = 0;
  int failures = 0;

  // slave behaviour: ready after dly[i] cycles of s_req, or constantly if always_rdy[i]
  int         dly [2];
  int         wc  [2];
  logic [1:0] always_rdy = '0;

  bus_interconnect_n #(.WIDTH(32), .N_SLAVES(2), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .rdata(rdata), .ack(ack), .err(err), .err_count(err_count), .s_req(s_req),
    .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be),
    .s_rdata(s_rdata), .s_ready(s_ready)
  );

  bus_interconnect_n #(.WIDTH(32), .N_SLAVES(2), .ADDR_BASE(64'h0), .ADDR_MASK(64'h0),
                       .TIMEOUT(TMO)) dut_ov (
    .clk(clk), .rst_n(rst_n), .req(ov_req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .rdata(ov_rdata), .ack(ov_ack), .err(ov_err), .err_count(ov_err_count), .s_req(ov_s_req),
    .s_we(ov_s_we), .s_addr(ov_s_addr), .s_wdata(ov_s_wdata), .s_be(ov_s_be),
    .s_rdata(s_rdata), .s_ready(ov_s_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic update_ready();
    for (int i = 0; i < 2; i++) begin
      if (s_req[i]) begin
        s_ready[i] = always_rdy[i] || (wc[i] >= dly[i]);
        wc[i]++;
      end else begin
        s_ready[i] = always_rdy[i];
        wc[i] = 0;
      end
    end
  endtask

  function automatic logic [7:0] sat_add(input logic [7:0] v, input logic e);
    return (e && v != 8'hFF) ? v + 8'd1 : v;
  endfunction

  // Behavioural model: region by upper address half, latency from slave delay.
  task automatic model(input logic twe, input logic [31:0] a, input int d0, input int d1,
                       input logic [1:0] ar, input logic [63:0] srd,
                       output int lat, output logic e, output logic [31:0] rd,
                       output logic [1:0] sel);
    int d;
    int idx;
    idx = (a[31:16] == 16'h0000) ? 0 : (a[31:16] == 16'h0001) ? 1 : -1;
    if (idx < 0) begin
      lat = 1; e = 1'b1; rd = '0; sel = 2'b00;
    end else begin
      sel = (idx == 0) ? 2'b01 : 2'b10;
      d = ar[idx] ? 0 : ((idx == 0) ? d0 : d1);
      if (d <= TMO) begin
        lat = 2 + d; e = 1'b0;
        rd = twe ? 32'h0 : ((idx == 0) ? srd[31:0] : srd[63:32]);
      end else begin
        lat = TMO + 2; e = 1'b1; rd = '0;
      end
    end
  endtask

  // One master transaction starting from IDLE, aligned 1 time unit after a clock edge.
  task automatic txn(input logic twe, input logic [31:0] taddr, input logic [31:0] twdata,
                     input logic [3:0] tbe, input bit scramble,
                     output int lat, output logic terr, output logic [31:0] trd,
                     output logic [1:0] sreq1, output logic [1:0] sreq_or,
                     output logic [1:0] sreq_ack, output logic [31:0] sa,
                     output logic [31:0] swd, output logic swe, output logic [3:0] sbe);
    req = 1'b1; we = twe; addr = taddr; wdata = twdata; be = tbe;
    lat = -1; terr = 1'b0; trd = '0; sreq1 = '0; sreq_or = '0; sreq_ack = '0;
    sa = '0; swd = '0; swe = 1'b0; sbe = '0;
    update_ready();
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 1) sreq1 = s_req;
      sreq_or = sreq_or | s_req;
      if (scramble) begin
        we = 1'($urandom); addr = $urandom; wdata = $urandom; be = 4'($urandom);
      end
      if (ack) begin
        lat = c; terr = err; trd = rdata; sreq_ack = s_req;
        sa = s_addr; swd = s_wdata; swe = s_we; sbe = s_be;
        break;
      end
      update_ready();
    end
    req = 1'b0;
    @(posedge clk); #1;
    update_ready();
    chk("ack_one_cycle", {31'b0, ack}, 32'h0);
    chk("rdata_hold", rdata, trd);
    chk("err_hold", {31'b0, err}, {31'b0, terr});
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          d0;
    int          d1;
    logic [1:0]  ar;
    int          lat;
    logic        err;
    logic [31:0] rd;
    logic [1:0]  sel;
  } vec_t;

  vec_t vt [8];

  initial begin
    int          lat, exp_lat, first_ack, second_ack;
    logic        terr, exp_err, swe;
    logic [31:0] trd, exp_rd, sa, swd, second_rd;
    logic [1:0]  sreq1, sreq_or, sreq_ack, exp_sel;
    logic [3:0]  sbe;
    logic [7:0]  exp_ec;
    logic        r_we;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_be;
    logic [1:0]  r_ar;
    int          r_d0, r_d1;

    vt[0] = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 0,  0,  2'b01, 2,  1'b0, 32'h8,         2'b01};
    vt[1] = '{1'b1, 32'h0001_0004, 32'd12,        4'hF, 0,  3,  2'b00, 5,  1'b0, 32'h0,         2'b10};
    vt[2] = '{1'b0, 32'h0002_0000, 32'h0,         4'hF, 0,  0,  2'b11, 1,  1'b1, 32'h0,         2'b00};
    vt[3] = '{1'b0, 32'h0000_0020, 32'h0,         4'hF, 99, 0,  2'b10, 17, 1'b1, 32'h0,         2'b01};
    vt[4] = '{1'b0, 32'h0001_FFFC, 32'h0,         4'h3, 0,  15, 2'b00, 17, 1'b0, 32'h1234_5678, 2'b10};
    vt[5] = '{1'b0, 32'h0001_0000, 32'h0,         4'h1, 0,  16, 2'b00, 17, 1'b1, 32'h0,         2'b10};
    vt[6] = '{1'b0, 32'hFFFF_0000, 32'h0,         4'hF, 0,  0,  2'b00, 1,  1'b1, 32'h0,         2'b00};
    vt[7] = '{1'b1, 32'h0000_FFFC, 32'hA5A5_5A5A, 4'hC, 1,  0,  2'b00, 3,  1'b0, 32'h0,         2'b01};

    dly[0] = 0; dly[1] = 0; wc[0] = 0; wc[1] = 0;
    s_rdata = {32'h1234_5678, 32'h0000_0008};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", {31'b0, ack}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_s_req", {30'b0, s_req}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_s_addr", s_addr, 32'h0);
    chk("rst_s_wdata", s_wdata, 32'h0);
    chk("rst_s_be_we", {27'b0, s_be, s_we}, 32'h0);
    chk("rst_err_count", {24'b0, err_count}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // directed vector table
    exp_ec = 8'd0;
    for (int k = 0; k < 8; k++) begin
      dly[0] = vt[k].d0; dly[1] = vt[k].d1; always_rdy = vt[k].ar;
      update_ready();
      txn(vt[k].we, vt[k].addr, vt[k].wdata, vt[k].be, bit'(k % 2),
          lat, terr, trd, sreq1, sreq_or, sreq_ack, sa, swd, swe, sbe);
      exp_ec = sat_add(exp_ec, vt[k].err);
      chk($sformatf("vec%0d_latency", k), 32'(lat), 32'(vt[k].lat));
      chk($sformatf("vec%0d_err", k), {31'b0, terr}, {31'b0, vt[k].err});
      chk($sformatf("vec%0d_rdata", k), trd, vt[k].rd);
      chk($sformatf("vec%0d_s_req_first", k), {30'b0, sreq1}, {30'b0, vt[k].sel});
      chk($sformatf("vec%0d_s_req_any", k), {30'b0, sreq_or}, {30'b0, vt[k].sel});
      chk($sformatf("vec%0d_s_req_at_ack", k), {30'b0, sreq_ack}, 32'h0);
      chk($sformatf("vec%0d_err_count", k), {24'b0, err_count}, {24'b0, exp_ec});
      if (vt[k].sel != 2'b00) begin
        chk($sformatf("vec%0d_s_addr", k), sa, vt[k].addr);
        chk($sformatf("vec%0d_s_wdata", k), swd, vt[k].wdata);
        chk($sformatf("vec%0d_s_we_be", k), {27'b0, sbe, swe}, {27'b0, vt[k].be, vt[k].we});
      end
    end
    always_rdy = 2'b00;

    // back-to-back: req held high across ack, replaced by a slave1 read
    dly[0] = 0; dly[1] = 0;
    first_ack = -1; second_ack = -1; second_rd = '0;
    req = 1'b1; we = 1'b0; addr = 32'h0000_0010;
    update_ready();
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (ack && first_ack < 0) begin
        first_ack = c; addr = 32'h0001_0008;
      end else if (ack) begin
        second_ack = c; second_rd = rdata; req = 1'b0;
        break;
      end
      update_ready();
    end
    req = 1'b0;
    @(posedge clk); #1; update_ready();
    chk("b2b_first_ack", 32'(first_ack), 32'd2);
    chk("b2b_second_ack", 32'(second_ack), 32'd5);
    chk("b2b_second_rdata", second_rd, 32'h1234_5678);

    // reset asserted mid-WAIT drops the transaction
    dly[0] = 99;
    req = 1'b1; we = 1'b0; addr = 32'h0000_0010;
    update_ready();
    @(posedge clk); #1; update_ready();
    chk("pre_rst_s_req", {30'b0, s_req}, 32'h1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_s_req", {30'b0, s_req}, 32'h0);
    chk("async_rst_ack", {31'b0, ack}, 32'h0);
    chk("async_rst_err_count", {24'b0, err_count}, 32'h0);
    chk("async_rst_s_addr", s_addr, 32'h0);
    req = 1'b0;
    @(posedge clk); #1;
    chk("rst_hold_ack", {31'b0, ack}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1; update_ready();
    dly[0] = 0;
    txn(1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b0,
        lat, terr, trd, sreq1, sreq_or, sreq_ack, sa, swd, swe, sbe);
    chk("post_rst_latency", 32'(lat), 32'd2);
    chk("post_rst_err", {31'b0, terr}, 32'h0);
    chk("post_rst_rdata", trd, 32'h8);
    exp_ec = 8'd0;

    // overlapping map: slave0 wins, slave1 ready alone never completes
    we = 1'b0; addr = 32'h3; ov_s_ready = 2'b10; ov_req = 1'b1;
    lat = -1; terr = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 1) chk("ov_s_req", {30'b0, ov_s_req}, 32'h1);
      if (ov_ack) begin
        lat = c; terr = ov_err; ov_req = 1'b0;
        break;
      end
    end
    ov_req = 1'b0;
    chk("ov_timeout_latency", 32'(lat), 32'(TMO + 2));
    chk("ov_timeout_err", {31'b0, terr}, 32'h1);
    @(posedge clk); #1;
    ov_s_ready = 2'b01; ov_req = 1'b1; lat = -1; trd = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (ov_ack) begin
        lat = c; terr = ov_err; trd = ov_rdata; ov_req = 1'b0;
        break;
      end
    end
    ov_req = 1'b0; ov_s_ready = 2'b00;
    chk("ov_read_latency", 32'(lat), 32'd2);
    chk("ov_read_err", {31'b0, terr}, 32'h0);
    chk("ov_read_rdata", trd, 32'h8);
    @(posedge clk); #1; update_ready();

    // randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      r_we = 1'($urandom);
      r_wdata = $urandom;
      r_be = 4'($urandom);
      case ($urandom_range(0, 2))
        0: r_addr = {16'h0000, 16'($urandom)};
        1: r_addr = {16'h0001, 16'($urandom)};
        default: r_addr = {16'($urandom_range(2, 65535)), 16'($urandom)};
      endcase
      r_d0 = $urandom_range(0, 18);
      r_d1 = $urandom_range(0, 18);
      r_ar = 2'($urandom);
      s_rdata = {$urandom, $urandom};
      dly[0] = r_d0; dly[1] = r_d1; always_rdy = r_ar;
      update_ready();
      model(r_we, r_addr, r_d0, r_d1, r_ar, s_rdata, exp_lat, exp_err, exp_rd, exp_sel);
      txn(r_we, r_addr, r_wdata, r_be, 1'b1,
          lat, terr, trd, sreq1, sreq_or, sreq_ack, sa, swd, swe, sbe);
      exp_ec = sat_add(exp_ec, exp_err);
      chk($sformatf("rnd%0d_latency", n), 32'(lat), 32'(exp_lat));
      chk($sformatf("rnd%0d_err", n), {31'b0, terr}, {31'b0, exp_err});
      chk($sformatf("rnd%0d_rdata", n), trd, exp_rd);
      chk($sformatf("rnd%0d_s_req", n), {30'b0, sreq_or}, {30'b0, exp_sel});
      chk($sformatf("rnd%0d_err_count", n), {24'b0, err_count}, {24'b0, exp_ec});
      if (exp_sel != 2'b00) begin
        chk($sformatf("rnd%0d_s_addr", n), sa, r_addr);
        chk($sformatf("rnd%0d_s_wdata_we_be", n), swd ^ {27'b0, sbe, swe},
            r_wdata ^ {27'b0, r_be, r_we});
      end
    end
    always_rdy = 2'b00;

    // err_count saturation after 260 unmapped accesses from reset
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1; update_ready();
    for (int n = 1; n <= 260; n++) begin
      txn(1'b0, 32'h0003_0000, 32'h0, 4'hF, 1'b0,
          lat, terr, trd, sreq1, sreq_or, sreq_ack, sa, swd, swe, sbe);
      if (n == 1) chk("sat_first_count", {24'b0, err_count}, 32'd1);
      if (n == 254) chk("sat_count_254", {24'b0, err_count}, 32'd254);
      if (n == 255) chk("sat_count_255", {24'b0, err_count}, 32'd255);
    end
    chk("sat_count_260", {24'b0, err_count}, 32'd255);
    chk("sat_last_err", {31'b0, terr}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
